// File: rtl/rv32i_pkg.sv
// Shared pipeline-control types: forward-select encodings, per-stage destination shadow
// and the register-match helper used by the hazard logic.
package rv32i_pkg;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef struct packed {
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } shadow_t;

    localparam shadow_t SHADOW_NONE = '{rd: 5'd0, we: 1'b0, ld: 1'b0};

    // x0 is hardwired, so it never matches a producer.
    function automatic logic shadow_hit(input logic we, input logic [4:0] rd, input logic [4:0] r);
        return we && (rd == r) && (r != 5'd0);
    endfunction

endpackage

// File: rtl/rv32i_fwd_sel.sv
// Per-operand forward select: EX/MEM result beats MEM/WB result, register file otherwise.
// Purely combinational; imm_sel_i pins the select to the register path so an immediate is never overridden.
module rv32i_fwd_sel
    import rv32i_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic       imm_sel_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_we_i,
    input  logic [4:0] mem_rd_i,
    input  logic       mem_we_i,
    output logic       hit_ex_o,
    output logic       hit_mem_o,
    output logic [1:0] sel_o
);

    always_comb begin
        hit_ex_o  = shadow_hit(ex_we_i, ex_rd_i, rs_i);
        hit_mem_o = shadow_hit(mem_we_i, mem_rd_i, rs_i);
        sel_o     = FWD_REG;
        if (!imm_sel_i) begin
            if (hit_ex_o) begin
                sel_o = FWD_EXMEM;
            end else if (hit_mem_o) begin
                sel_o = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/rv32i_hazard_ctrl.sv
// Hazard/forwarding sequencer: tracks EX/MEM destinations, raises load-use and store-data stalls,
// flushes on taken branches, and registers the operand forward selects alongside ID/EX.
module rv32i_hazard_ctrl
    import rv32i_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic             id_alusrc_i,
    input  logic [4:0]       id_rd_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             branch_taken_i,
    output logic             stall_o,
    output logic             flush_ifid_o,
    output logic             bubble_idex_o,
    output logic [1:0]       ctrl_mux1_o,
    output logic [1:0]       ctrl_mux2_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // The regfile writes before it reads, so nothing past MEM needs tracking.
    shadow_t          ex_q, ex_d;
    logic [4:0]       mem_rd_q;
    logic             mem_we_q;
    logic [1:0]       mux1_q, mux1_d, mux2_q, mux2_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic       hit_ex1, hit_mem1, hit_ex2, hit_mem2;
    logic [1:0] sel1, sel2;
    logic       load_use, store_data, stall, advance;

    rv32i_fwd_sel u_fwd_a (
        .rs_i      (id_rs1_i),
        .imm_sel_i (1'b0),
        .ex_rd_i   (ex_q.rd),
        .ex_we_i   (ex_q.we),
        .mem_rd_i  (mem_rd_q),
        .mem_we_i  (mem_we_q),
        .hit_ex_o  (hit_ex1),
        .hit_mem_o (hit_mem1),
        .sel_o     (sel1)
    );

    rv32i_fwd_sel u_fwd_b (
        .rs_i      (id_rs2_i),
        .imm_sel_i (id_alusrc_i),
        .ex_rd_i   (ex_q.rd),
        .ex_we_i   (ex_q.we),
        .mem_rd_i  (mem_rd_q),
        .mem_we_i  (mem_we_q),
        .hit_ex_o  (hit_ex2),
        .hit_mem_o (hit_mem2),
        .sel_o     (sel2)
    );

    always_comb begin
        load_use    = ex_q.ld && ((id_uses_rs1_i && hit_ex1) ||
                                  (id_uses_rs2_i && !id_alusrc_i && hit_ex2));
        // Store data takes the unforwarded REG2 path, so wait until the producer leaves MEM.
        store_data  = id_uses_rs2_i && id_alusrc_i && (hit_ex2 || hit_mem2);
        stall       = id_valid_i && (load_use || store_data) && !branch_taken_i;
        advance     = id_valid_i && !stall && !branch_taken_i;

        ex_d        = SHADOW_NONE;
        mux1_d      = FWD_REG;
        mux2_d      = FWD_REG;
        if (advance) begin
            ex_d   = '{rd: id_rd_i, we: id_regwrite_i, ld: id_memread_i};
            mux1_d = sel1;
            mux2_d = sel2;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (branch_taken_i && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= SHADOW_NONE;
            mem_rd_q    <= 5'd0;
            mem_we_q    <= 1'b0;
            mux1_q      <= FWD_REG;
            mux2_q      <= FWD_REG;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_rd_q    <= ex_q.rd;
            mem_we_q    <= ex_q.we;
            mux1_q      <= mux1_d;
            mux2_q      <= mux2_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_o       = stall;
    assign flush_ifid_o  = branch_taken_i;
    assign bubble_idex_o = stall || branch_taken_i;
    assign ctrl_mux1_o   = mux1_q;
    assign ctrl_mux2_o   = mux2_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;

endmodule
